// File: rtl/uart_txq_pkg.sv
// Shared types and default timing constants for the UART transmit queue feeder.
// All values assume a 384 kHz system clock (40 clocks per bit at 9600 baud).
package uart_txq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    ACK,
    WAIT_DONE,
    GAP
  } txq_state_e;

  localparam int SEND_HOLD    = 44;
  localparam int GUARD        = 40;
  localparam int BUSY_TIMEOUT = 80;
  localparam int CLKS_PER_BIT = 40;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/uart_txq_feeder_if.sv
// Link between the transmit queue feeder (master) and the downstream UART (slave).
interface uart_txq_feeder_if;
  logic       send;
  logic [7:0] data_in;
  logic       busy;
  logic       done;
  logic [7:0] data_out;

  modport master (
    output send,
    output data_in,
    input  busy,
    input  done,
    input  data_out
  );

  modport slave (
    input  send,
    input  data_in,
    output busy,
    output done,
    output data_out
  );
endinterface

// File: rtl/uart_txq_fifo.sv
// Circular byte buffer with registered full/empty/count and a sticky overflow flag.
module uart_txq_fifo import uart_txq_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        pop,
  output logic [7:0]  rd_data,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count,
  output logic        ovf
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          do_pop;
  logic [AW:0]   count_nxt;

  // Acceptance uses the pre-edge flags, so a write while full is rejected even if a pop frees a slot.
  always_comb begin
    push      = wr_en && !full;
    do_pop    = pop && !empty;
    count_nxt = count;
    if (push && !do_pop) begin
      count_nxt = count + 1'b1;
    end else if (!push && do_pop) begin
      count_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_CNT);
      empty <= (count_nxt == '0);
      if (wr_en && full) begin
        ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_txq_feeder.sv
// Byte queue feeding a UART send/data_in handshake with hold, busy timeout and guard gap.
// Optional loopback comparator enabled by defining UART_TXQ_LOOPBACK_CHECK_EN.
module uart_txq_feeder import uart_txq_pkg::*; #(
  parameter int DEPTH        = 16,
  parameter int SEND_HOLD    = uart_txq_pkg::SEND_HOLD,
  parameter int GUARD        = uart_txq_pkg::GUARD,
  parameter int BUSY_TIMEOUT = uart_txq_pkg::BUSY_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ovf,
  output logic                   tx_drop,
  output logic                   lb_err,
  uart_txq_feeder_if.master      uart
);

  localparam int CNT_MAX = max3(SEND_HOLD, GUARD, BUSY_TIMEOUT);
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] HOLD_LOAD    = CW'(SEND_HOLD - 1);
  localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(BUSY_TIMEOUT - 1);
  localparam logic [CW-1:0] GUARD_LOAD   = CW'(GUARD - 1);

  txq_state_e    state;
  txq_state_e    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          busy_seen;
  logic          busy_seen_nxt;
  logic          drop_nxt;
  logic          pop;
  logic          send_q;
  logic [7:0]    data_q;
  logic [7:0]    fifo_head;

  uart_txq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .pop     (pop),
    .rd_data (fifo_head),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .ovf     (ovf)
  );

  // One down-counter times the send hold, the busy timeout and the guard gap in turn.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    busy_seen_nxt = busy_seen;
    drop_nxt      = 1'b0;
    pop           = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty && !uart.busy) begin
          pop           = 1'b1;
          busy_seen_nxt = 1'b0;
          cnt_nxt       = HOLD_LOAD;
          state_nxt     = ISSUE;
        end
      end
      ISSUE: begin
        if (uart.busy) begin
          busy_seen_nxt = 1'b1;
        end
        if (cnt == '0) begin
          cnt_nxt   = TIMEOUT_LOAD;
          state_nxt = ACK;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ACK: begin
        if (busy_seen || uart.busy) begin
          state_nxt = WAIT_DONE;
        end else if (cnt == '0) begin
          drop_nxt  = 1'b1;
          cnt_nxt   = GUARD_LOAD;
          state_nxt = GAP;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!uart.busy) begin
          cnt_nxt   = GUARD_LOAD;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // send is registered off the next state so it is high exactly while in ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      busy_seen <= 1'b0;
      send_q    <= 1'b0;
      data_q    <= 8'h00;
      tx_drop   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      busy_seen <= busy_seen_nxt;
      send_q    <= (state_nxt == ISSUE);
      tx_drop   <= drop_nxt;
      if (pop) begin
        data_q <= fifo_head;
      end
    end
  end

  assign uart.send    = send_q;
  assign uart.data_in = data_q;

`ifdef UART_TXQ_LOOPBACK_CHECK_EN
  logic lb_err_q;

  // A done that arrives outside the post-issue window belongs to no byte we sent.
  always_ff @(posedge clk) begin
    if (reset) begin
      lb_err_q <= 1'b0;
    end else if (uart.done && (state == WAIT_DONE || state == GAP) &&
                 (uart.data_out != data_q)) begin
      lb_err_q <= 1'b1;
    end
  end

  assign lb_err = lb_err_q;
`else
  logic unused_lb;
  assign unused_lb = ^{uart.done, uart.data_out};
  assign lb_err    = 1'b0;
`endif

endmodule
